// File: rtl/sp_pkg.sv
// Shared definitions for the SP lane memory path.
//   seq_state_e  : sequencer state encoding (IDLE/ISSUE/DRAIN/DONE)
//   MEM_LAT_*    : supported memory read latency range
//   lane_lsb     : lane-packing index helper (lane i at bits [i*W +: W])
//   clamp_lat    : folds a latency parameter into the supported range
package sp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 4;

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

  function automatic int unsigned clamp_lat(input int unsigned lat);
    if (lat < MEM_LAT_MIN) return MEM_LAT_MIN;
    if (lat > MEM_LAT_MAX) return MEM_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/sp_lane_mem_sequencer_if.sv
// Shared memory port between the lane sequencer (master) and SM data memory (slave).
//   mem_req/mem_we/mem_addr/mem_wdata : request, held stable while mem_ready=0
//   mem_ready                         : memory accepts the request this cycle
//   mem_rdata                         : load data, MEM_LAT cycles after acceptance
interface sp_lane_mem_sequencer_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/sp_lowest_pending.sv
// Combinational priority encoder over the pending-lane mask.
//   pend     : pending-lane mask
//   idx      : index of the lowest set bit (0 when none set)
//   any_pend : at least one bit of pend is set
module sp_lowest_pending #(
  parameter int unsigned N_LANES = 8,
  parameter int unsigned IDX_W   = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic [N_LANES-1:0] pend,
  output logic [IDX_W-1:0]   idx,
  output logic               any_pend
);

  always_comb begin
    idx      = '0;
    any_pend = 1'b0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      if (pend[i] && !any_pend) begin
        idx      = IDX_W'(i);
        any_pend = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sp_lane_mem_sequencer.sv
// Serialises the memory operations of all enabled lanes of a warp onto one
// shared memory port; optionally merges loads to identical addresses.
//   clk, reset (async, active-low)
//   start/we/lane_en/lane_addr/lane_wdata : warp op launch, sampled in IDLE
//   busy, done                            : op in flight / one-cycle completion
//   lane_rdata, lane_rvalid               : registered per-lane load results
//   mem                                   : shared memory port (master side)
module sp_lane_mem_sequencer
  import sp_pkg::*;
#(
  parameter int unsigned N_LANES  = 8,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned MEM_LAT  = 1,
  parameter bit          COALESCE = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      we,
  input  logic [N_LANES-1:0]        lane_en,
  input  logic [N_LANES*ADDR_W-1:0] lane_addr,
  input  logic [N_LANES*DATA_W-1:0] lane_wdata,
  output logic                      busy,
  output logic                      done,
  output logic [N_LANES*DATA_W-1:0] lane_rdata,
  output logic [N_LANES-1:0]        lane_rvalid,
  sp_lane_mem_sequencer_if.master   mem
);

  localparam int unsigned LAT   = clamp_lat(MEM_LAT);
  localparam int unsigned IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  seq_state_e                  state_q, state_d;
  logic                        we_q, we_d;
  logic [N_LANES-1:0]          pend_q, pend_d;
  logic [N_LANES*ADDR_W-1:0]   addr_q, addr_d;
  logic [N_LANES*DATA_W-1:0]   wdata_q, wdata_d;
  logic [N_LANES*DATA_W-1:0]   lane_rdata_q, lane_rdata_d;
  logic [N_LANES-1:0]          lane_rvalid_q, lane_rvalid_d;
  logic [LAT-1:0]              pipe_vld_q, pipe_vld_d;
  logic [LAT-1:0][N_LANES-1:0] pipe_mask_q, pipe_mask_d;

  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [N_LANES-1:0] issue_mask;
  logic               drain_busy;
  logic               req_c;
  logic               req_we_c;
  logic [ADDR_W-1:0]  req_addr_c;
  logic [DATA_W-1:0]  req_wdata_c;

  sp_lowest_pending #(
    .N_LANES (N_LANES),
    .IDX_W   (IDX_W)
  ) u_lowest_pending (
    .pend     (pend_q),
    .idx      (sel_idx),
    .any_pend (sel_any)
  );

  // Selected lane's captured address/data, and the set of lanes this request
  // retires: the selected lane plus, for coalesced loads, every pending lane
  // sharing its address.
  always_comb begin
    sel_addr   = '0;
    sel_wdata  = '0;
    issue_mask = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      if (IDX_W'(i) == sel_idx) begin
        sel_addr  = addr_q[lane_lsb(i, ADDR_W) +: ADDR_W];
        sel_wdata = wdata_q[lane_lsb(i, DATA_W) +: DATA_W];
      end
    end
    for (int unsigned i = 0; i < N_LANES; i++) begin
      if (pend_q[i]) begin
        if (IDX_W'(i) == sel_idx) begin
          issue_mask[i] = 1'b1;
        end else if (COALESCE && !we_q &&
                     (addr_q[lane_lsb(i, ADDR_W) +: ADDR_W] == sel_addr)) begin
          issue_mask[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    pend_d        = pend_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    lane_rdata_d  = lane_rdata_q;
    lane_rvalid_d = lane_rvalid_q;
    pipe_vld_d    = '0;
    pipe_mask_d   = '0;
    drain_busy    = 1'b0;
    req_c         = 1'b0;
    req_we_c      = 1'b0;
    req_addr_c    = '0;
    req_wdata_c   = '0;

    for (int unsigned j = 1; j < LAT; j++) begin
      pipe_vld_d[j]  = pipe_vld_q[j-1];
      pipe_mask_d[j] = pipe_mask_q[j-1];
    end

    // Entries behind the output stage still owe data; the output stage is
    // captured this cycle, so it does not hold DRAIN open.
    for (int unsigned j = 0; j + 1 < LAT; j++) begin
      drain_busy = drain_busy | pipe_vld_q[j];
    end

    if (pipe_vld_q[LAT-1]) begin
      for (int unsigned i = 0; i < N_LANES; i++) begin
        if (pipe_mask_q[LAT-1][i]) begin
          lane_rdata_d[lane_lsb(i, DATA_W) +: DATA_W] = mem.mem_rdata;
          lane_rvalid_d[i] = 1'b1;
        end
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          we_d          = we;
          pend_d        = lane_en;
          addr_d        = lane_addr;
          wdata_d       = lane_wdata;
          lane_rvalid_d = '0;
          state_d       = (lane_en == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (sel_any) begin
          req_c       = 1'b1;
          req_we_c    = we_q;
          req_addr_c  = sel_addr;
          req_wdata_c = sel_wdata;
          if (mem.mem_ready) begin
            pend_d = pend_q & ~issue_mask;
            if (!we_q) begin
              pipe_vld_d[0]  = 1'b1;
              pipe_mask_d[0] = issue_mask;
            end
            if ((pend_q & ~issue_mask) == '0) begin
              state_d = we_q ? ST_DONE : ST_DRAIN;
            end
          end
        end else begin
          state_d = we_q ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!drain_busy) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      we_q          <= 1'b0;
      pend_q        <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      lane_rdata_q  <= '0;
      lane_rvalid_q <= '0;
      pipe_vld_q    <= '0;
      pipe_mask_q   <= '0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      pend_q        <= pend_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      lane_rdata_q  <= lane_rdata_d;
      lane_rvalid_q <= lane_rvalid_d;
      pipe_vld_q    <= pipe_vld_d;
      pipe_mask_q   <= pipe_mask_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign lane_rdata    = lane_rdata_q;
  assign lane_rvalid   = lane_rvalid_q;
  assign mem.mem_req   = req_c;
  assign mem.mem_we    = req_we_c;
  assign mem.mem_addr  = req_addr_c;
  assign mem.mem_wdata = req_wdata_c;

endmodule

// File: tb/tb_sp_lane_mem_sequencer.sv
// Directed bench for sp_lane_mem_sequencer: two instances share stimulus,
// u_dut0 (COALESCE=1, MEM_LAT=1) and u_dut1 (COALESCE=0, MEM_LAT=2).
module tb_sp_lane_mem_sequencer;

  localparam int N       = 8;
  localparam int AW      = 16;
  localparam int DW      = 16;
  localparam int RUN_CYC = 24;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            we = 1'b0;
  logic [N-1:0]    lane_en = '0;
  logic [N*AW-1:0] lane_addr = '0;
  logic [N*DW-1:0] lane_wdata = '0;
  logic            mem_ready = 1'b1;

  logic            busy0, done0, busy1, done1;
  logic [N*DW-1:0] lane_rdata0, lane_rdata1;
  logic [N-1:0]    lane_rvalid0, lane_rvalid1;

  int checks = 0;
  int errors = 0;

  sp_lane_mem_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) m0 ();
  sp_lane_mem_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) m1 ();

  sp_lane_mem_sequencer #(
    .N_LANES(N), .DATA_W(DW), .ADDR_W(AW), .MEM_LAT(1), .COALESCE(1'b1)
  ) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .we(we), .lane_en(lane_en),
    .lane_addr(lane_addr), .lane_wdata(lane_wdata), .busy(busy0), .done(done0),
    .lane_rdata(lane_rdata0), .lane_rvalid(lane_rvalid0), .mem(m0)
  );

  sp_lane_mem_sequencer #(
    .N_LANES(N), .DATA_W(DW), .ADDR_W(AW), .MEM_LAT(2), .COALESCE(1'b0)
  ) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .we(we), .lane_en(lane_en),
    .lane_addr(lane_addr), .lane_wdata(lane_wdata), .busy(busy1), .done(done1),
    .lane_rdata(lane_rdata1), .lane_rvalid(lane_rvalid1), .mem(m1)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] fmem(input logic [15:0] a);
    return {a[7:0], ~a[7:0]};
  endfunction

  // Memory models: load data is a fixed function of address; stores are logged.
  logic [15:0] rd0, rd1a, rd1b;
  int          req_cnt0 = 0, req_cnt1 = 0, wr_cnt0 = 0, wr_cnt1 = 0;
  logic [15:0] wr_addr0 [0:63];
  logic [15:0] wr_data0 [0:63];

  assign m0.mem_ready = mem_ready;
  assign m1.mem_ready = mem_ready;
  assign m0.mem_rdata = rd0;
  assign m1.mem_rdata = rd1b;

  always @(posedge clk) begin
    if (m0.mem_req && m0.mem_ready) begin
      req_cnt0 <= req_cnt0 + 1;
      if (m0.mem_we) begin
        wr_addr0[wr_cnt0 % 64] <= m0.mem_addr;
        wr_data0[wr_cnt0 % 64] <= m0.mem_wdata;
        wr_cnt0 <= wr_cnt0 + 1;
      end
    end
    if (m1.mem_req && m1.mem_ready) begin
      req_cnt1 <= req_cnt1 + 1;
      if (m1.mem_we) wr_cnt1 <= wr_cnt1 + 1;
    end
    rd0  <= fmem(m0.mem_addr);
    rd1a <= fmem(m1.mem_addr);
    rd1b <= rd1a;
  end

  // Per-run observations, indexed by cycle number (cycle 0 = start accepted).
  logic        req0_tr  [0:31];
  logic        req1_tr  [0:31];
  logic [15:0] addr0_tr [0:31];
  logic        busy0_tr [0:31];
  int          done0_cyc, done1_cyc, done0_cnt, done1_cnt;
  logic [N-1:0] rv0_at_done, rv1_at_done;

  task automatic run_op(input logic op_we, input logic [N-1:0] op_en,
                        input logic [N*AW-1:0] op_addr, input logic [N*DW-1:0] op_wdata,
                        input int stall_lo, input int stall_hi, input int pulse_cyc);
    @(posedge clk); #1;
    we = op_we; lane_en = op_en; lane_addr = op_addr; lane_wdata = op_wdata;
    start = 1'b1; mem_ready = 1'b1;
    done0_cyc = 0; done1_cyc = 0; done0_cnt = 0; done1_cnt = 0;
    rv0_at_done = '0; rv1_at_done = '0;
    for (int c = 1; c < RUN_CYC; c++) begin
      @(posedge clk); #1;
      start = (c == pulse_cyc);
      if (c == 1) begin
        we = ~op_we; lane_en = ~op_en; lane_addr = ~op_addr; lane_wdata = ~op_wdata;
      end
      mem_ready = !(c >= stall_lo && c <= stall_hi);
      req0_tr[c]  = m0.mem_req;
      req1_tr[c]  = m1.mem_req;
      addr0_tr[c] = m0.mem_addr;
      busy0_tr[c] = busy0;
      if (done0) begin
        if (done0_cnt == 0) begin done0_cyc = c; rv0_at_done = lane_rvalid0; end
        done0_cnt++;
      end
      if (done1) begin
        if (done1_cnt == 0) begin done1_cyc = c; rv1_at_done = lane_rvalid1; end
        done1_cnt++;
      end
    end
    start = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy0, done0, lane_rvalid0, lane_rdata0, m0.mem_req, m0.mem_we, m0.mem_addr, m0.mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_outputs0 got busy=%b done=%b rv=%h req=%b addr=%h", busy0, done0, lane_rvalid0, m0.mem_req, m0.mem_addr);
    end
    checks++;
    if ({busy1, done1, lane_rvalid1, lane_rdata1, m1.mem_req, m1.mem_we, m1.mem_addr, m1.mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_outputs1 got busy=%b done=%b rv=%h req=%b addr=%h", busy1, done1, lane_rvalid1, m1.mem_req, m1.mem_addr);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic check_linear_load(input string tag);
    logic [N*DW-1:0] exp;
    for (int i = 0; i < N; i++) exp[i*DW +: DW] = fmem(16'(i * 2));
    checks++;
    if (done0_cyc !== 10) begin errors++; $display("FAIL %s_done0 got %0d exp 10", tag, done0_cyc); end
    checks++;
    if (done1_cyc !== 11) begin errors++; $display("FAIL %s_done1 got %0d exp 11", tag, done1_cyc); end
    checks++;
    if (lane_rdata0 !== exp) begin errors++; $display("FAIL %s_rdata0 got %h exp %h", tag, lane_rdata0, exp); end
    checks++;
    if (lane_rdata1 !== exp) begin errors++; $display("FAIL %s_rdata1 got %h exp %h", tag, lane_rdata1, exp); end
    checks++;
    if (rv0_at_done !== 8'hFF) begin errors++; $display("FAIL %s_rvalid0_at_done got %h exp ff", tag, rv0_at_done); end
    checks++;
    if (rv1_at_done !== 8'hFF) begin errors++; $display("FAIL %s_rvalid1_at_done got %h exp ff", tag, rv1_at_done); end
  endtask

  task automatic test_load_linear();
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] w;
    int r0, r1;
    logic addr_ok;
    for (int i = 0; i < N; i++) begin a[i*AW +: AW] = 16'(i * 2); w[i*DW +: DW] = 16'(16'h7700 + i); end
    r0 = req_cnt0; r1 = req_cnt1;
    run_op(1'b0, 8'hFF, a, w, 0, -1, 0);
    check_linear_load("load");
    checks++;
    if (req_cnt0 - r0 !== 8) begin errors++; $display("FAIL load_reqs0 got %0d exp 8", req_cnt0 - r0); end
    addr_ok = 1'b1;
    for (int c = 1; c <= 8; c++) if (req0_tr[c] !== 1'b1 || addr0_tr[c] !== 16'((c - 1) * 2)) addr_ok = 1'b0;
    checks++;
    if (addr_ok !== 1'b1) begin errors++; $display("FAIL load_addr_order got cyc1=%h cyc8=%h exp 0000..000e", addr0_tr[1], addr0_tr[8]); end
    checks++;
    if ({busy0_tr[1], busy0_tr[10], busy0_tr[11]} !== 3'b110) begin
      errors++; $display("FAIL load_busy_window got %b exp 110", {busy0_tr[1], busy0_tr[10], busy0_tr[11]});
    end
  endtask

  task automatic test_coalesce();
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] exp;
    int r0, r1;
    for (int i = 0; i < N; i++) begin a[i*AW +: AW] = 16'h0040; exp[i*DW +: DW] = 16'h40BF; end
    r0 = req_cnt0; r1 = req_cnt1;
    run_op(1'b0, 8'hFF, a, '0, 0, -1, 0);
    checks++;
    if (req_cnt0 - r0 !== 1) begin errors++; $display("FAIL coal_reqs0 got %0d exp 1", req_cnt0 - r0); end
    checks++;
    if (req_cnt1 - r1 !== 8) begin errors++; $display("FAIL coal_reqs1 got %0d exp 8", req_cnt1 - r1); end
    checks++;
    if (done0_cyc !== 3) begin errors++; $display("FAIL coal_done0 got %0d exp 3", done0_cyc); end
    checks++;
    if (done1_cyc !== 11) begin errors++; $display("FAIL coal_done1 got %0d exp 11", done1_cyc); end
    checks++;
    if (lane_rdata0 !== exp || lane_rvalid0 !== 8'hFF) begin
      errors++; $display("FAIL coal_rdata0 got %h/%h exp %h/ff", lane_rdata0, lane_rvalid0, exp);
    end
    checks++;
    if (lane_rdata1 !== exp || lane_rvalid1 !== 8'hFF) begin
      errors++; $display("FAIL coal_rdata1 got %h/%h exp %h/ff", lane_rdata1, lane_rvalid1, exp);
    end
  endtask

  task automatic test_store();
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] w;
    int b0, b1;
    for (int i = 0; i < N; i++) begin a[i*AW +: AW] = 16'h0077; w[i*DW +: DW] = 16'(16'h1100 + i); end
    a[0*AW +: AW] = 16'h0010; a[2*AW +: AW] = 16'h0020; a[5*AW +: AW] = 16'h0030; a[7*AW +: AW] = 16'h0010;
    b0 = wr_cnt0; b1 = wr_cnt1;
    run_op(1'b1, 8'b1010_0101, a, w, 0, -1, 0);
    checks++;
    if (done0_cyc !== 5 || done1_cyc !== 5) begin errors++; $display("FAIL store_done got %0d/%0d exp 5/5", done0_cyc, done1_cyc); end
    checks++;
    if (wr_cnt0 - b0 !== 4 || wr_cnt1 - b1 !== 4) begin
      errors++; $display("FAIL store_writes got %0d/%0d exp 4/4", wr_cnt0 - b0, wr_cnt1 - b1);
    end
    checks++;
    if ({wr_addr0[b0 % 64], wr_addr0[(b0 + 1) % 64], wr_addr0[(b0 + 2) % 64], wr_addr0[(b0 + 3) % 64]} !== 64'h0010_0020_0030_0010) begin
      errors++; $display("FAIL store_order got %h %h %h %h exp 0010 0020 0030 0010",
                         wr_addr0[b0 % 64], wr_addr0[(b0 + 1) % 64], wr_addr0[(b0 + 2) % 64], wr_addr0[(b0 + 3) % 64]);
    end
    checks++;
    if (wr_data0[b0 % 64] !== 16'h1100 || wr_data0[(b0 + 3) % 64] !== 16'h1107) begin
      errors++; $display("FAIL store_data got first=%h last=%h exp 1100 1107", wr_data0[b0 % 64], wr_data0[(b0 + 3) % 64]);
    end
    checks++;
    if (lane_rvalid0 !== 8'h00 || lane_rvalid1 !== 8'h00) begin
      errors++; $display("FAIL store_rvalid got %h/%h exp 00/00", lane_rvalid0, lane_rvalid1);
    end
  endtask

  task automatic test_backpressure();
    logic [N*AW-1:0] a;
    logic [4*DW-1:0] exp;
    for (int i = 0; i < N; i++) a[i*AW +: AW] = (i < 4) ? 16'(i * 4) : 16'h0099;
    for (int i = 0; i < 4; i++) exp[i*DW +: DW] = fmem(16'(i * 4));
    run_op(1'b0, 8'h0F, a, '0, 0, -1, 0);
    checks++;
    if (done0_cyc !== 6 || done1_cyc !== 7) begin errors++; $display("FAIL bp_nostall_done got %0d/%0d exp 6/7", done0_cyc, done1_cyc); end
    run_op(1'b0, 8'h0F, a, '0, 2, 4, 0);
    checks++;
    if (done0_cyc !== 9 || done1_cyc !== 10) begin errors++; $display("FAIL bp_stall_done got %0d/%0d exp 9/10", done0_cyc, done1_cyc); end
    checks++;
    if ({req0_tr[2], req0_tr[3], req0_tr[4]} !== 3'b111 ||
        addr0_tr[2] !== 16'h0004 || addr0_tr[3] !== 16'h0004 || addr0_tr[4] !== 16'h0004) begin
      errors++; $display("FAIL bp_addr_hold got %h %h %h exp 0004 0004 0004", addr0_tr[2], addr0_tr[3], addr0_tr[4]);
    end
    checks++;
    if (lane_rdata0[4*DW-1:0] !== exp || lane_rvalid0 !== 8'h0F) begin
      errors++; $display("FAIL bp_rdata0 got %h/%h exp %h/0f", lane_rdata0[4*DW-1:0], lane_rvalid0, exp);
    end
    checks++;
    if (lane_rdata1[4*DW-1:0] !== exp || lane_rvalid1 !== 8'h0F) begin
      errors++; $display("FAIL bp_rdata1 got %h/%h exp %h/0f", lane_rdata1[4*DW-1:0], lane_rvalid1, exp);
    end
  endtask

  task automatic test_edge_starts();
    logic [N*AW-1:0] a;
    int r0, r1;
    logic any_req;
    for (int i = 0; i < N; i++) a[i*AW +: AW] = 16'(i * 2);
    r0 = req_cnt0; r1 = req_cnt1;
    run_op(1'b0, 8'h00, a, '0, 0, -1, 0);
    checks++;
    if (done0_cyc !== 1 || done1_cyc !== 1) begin errors++; $display("FAIL empty_done got %0d/%0d exp 1/1", done0_cyc, done1_cyc); end
    any_req = 1'b0;
    for (int c = 1; c < RUN_CYC; c++) any_req = any_req | req0_tr[c] | req1_tr[c];
    checks++;
    if (any_req !== 1'b0 || req_cnt0 !== r0 || req_cnt1 !== r1) begin
      errors++; $display("FAIL empty_no_traffic got req_seen=%b reqs=%0d/%0d exp 0 0/0", any_req, req_cnt0 - r0, req_cnt1 - r1);
    end
    checks++;
    if (lane_rvalid0 !== 8'h00) begin errors++; $display("FAIL empty_rvalid_clear got %h exp 00", lane_rvalid0); end
    r0 = req_cnt0; r1 = req_cnt1;
    run_op(1'b0, 8'hFF, a, '0, 0, -1, 3);
    checks++;
    if (done0_cnt !== 1 || done1_cnt !== 1) begin errors++; $display("FAIL busy_start_dones got %0d/%0d exp 1/1", done0_cnt, done1_cnt); end
    checks++;
    if (req_cnt0 - r0 !== 8 || req_cnt1 - r1 !== 8) begin
      errors++; $display("FAIL busy_start_reqs got %0d/%0d exp 8/8", req_cnt0 - r0, req_cnt1 - r1);
    end
    check_linear_load("busy_start");
  endtask

  task automatic test_mid_reset();
    logic [N*AW-1:0] a;
    logic stale;
    for (int i = 0; i < N; i++) a[i*AW +: AW] = 16'(i * 2);
    @(posedge clk); #1;
    we = 1'b0; lane_en = 8'hFF; lane_addr = a; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b0;
    #1;
    checks++;
    if ({busy0, done0, lane_rvalid0, lane_rdata0, m0.mem_req, m0.mem_addr} !== '0) begin
      errors++; $display("FAIL midreset_outputs0 got busy=%b rv=%h rdata=%h req=%b", busy0, lane_rvalid0, lane_rdata0, m0.mem_req);
    end
    checks++;
    if ({busy1, done1, lane_rvalid1, lane_rdata1, m1.mem_req, m1.mem_addr} !== '0) begin
      errors++; $display("FAIL midreset_outputs1 got busy=%b rv=%h rdata=%h req=%b", busy1, lane_rvalid1, lane_rdata1, m1.mem_req);
    end
    @(posedge clk); #1 reset = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (lane_rvalid0 !== '0 || lane_rvalid1 !== '0 || busy0 || busy1) stale = 1'b1;
    end
    checks++;
    if (stale !== 1'b0) begin errors++; $display("FAIL midreset_stale got 1 exp 0"); end
    run_op(1'b0, 8'hFF, a, '0, 0, -1, 0);
    check_linear_load("after_reset");
  endtask

  initial begin
    test_reset();
    test_load_linear();
    test_coalesce();
    test_store();
    test_backpressure();
    test_edge_starts();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sp_lane_mem_sequencer.md
# sp_lane_mem_sequencer

Parametrised successor to the per-lane memory wiring of the SP core array. Instead of one memory port per lane, it serialises the memory operations of all enabled lanes in a warp onto a single shared memory port. When COALESCE is set, it merges same-address loads into one request. It sits between the N-lane SP core array and the SM data memory, and reports per-lane read data plus a single completion pulse.

## Interface
- N_LANES, 8, number of SP lanes (1..32)
- DATA_W, 16, data width
- ADDR_W, 16, address width
- MEM_LAT, 1, fixed memory read latency in cycles (1..4)
- COALESCE, 1, 1 = merge loads to identical addresses; 0 = one request per lane
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  launch one warp memory op (accepted only in IDLE)
- we  in  1  1 = store, 0 = load; sampled with start
- lane_en  in  N_LANES  active-lane mask; sampled with start
- lane_addr  in  N_LANES*ADDR_W  per-lane address, lane i at bits [i*ADDR_W +: ADDR_W]
- lane_wdata  in  N_LANES*DATA_W  per-lane store data, same packing
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- lane_rdata  out  N_LANES*DATA_W  registered load results
- lane_rvalid  out  N_LANES  lane i load result valid
- mem_req  out  1  request valid
- mem_we  out  1  request is a store
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  request store data
- mem_ready  in  1  memory accepts the request this cycle
- mem_rdata  in  DATA_W  load data, valid exactly MEM_LAT cycles after acceptance

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE behaviour:
  - start=1 captures we, lane_en (into the pending mask), lane_addr and lane_wdata into internal registers. Lane inputs may change afterwards.
  - The same start clears lane_rvalid.
  - Next state is ISSUE, or DONE if lane_en==0.
- ISSUE behaviour:
  - The selected lane is the lowest-index pending lane.
  - The block drives mem_req=1 with that lane's address/data and the captured we.
  - On mem_req & mem_ready: clear the selected pending bit.
  - For a load, push {valid, lane mask} into a MEM_LAT-deep return pipe.
  - With COALESCE=1 and a load, the mask and the cleared bits include every pending lane whose address equals the selected address.
  - Stores are never coalesced. They issue in ascending lane order, so on duplicate addresses the highest lane's data is written last.
  - mem_addr, mem_wdata and mem_we stay stable while mem_req=1 and mem_ready=0.
  - Leave ISSUE when the last pending bit clears: go to DRAIN for loads, DONE for stores.
- Return pipe: when the pipe output is valid, write mem_rdata into lane_rdata for every lane in its mask and set those lane_rvalid bits.
- DRAIN: go to DONE once the return pipe is empty, counting the capture in that same cycle.
- DONE: done=1 for one cycle, then IDLE.
- start while not in IDLE is ignored.
- Reset values: every output 0, state IDLE, pending mask 0, return pipe cleared.
- Reset mid-operation aborts the op. Data returning from already-accepted requests is discarded.

## Timing
- Cycle 0: start accepted. Cycle 1: first mem_req. busy=1 from cycle 1 through the done cycle inclusive.
- With mem_ready held at 1, K requests issue back-to-back in cycles 1..K (K = unique addresses for coalesced loads, otherwise the popcount of lane_en).
- Store done: cycle K+1.
- Load:
  - A request accepted in cycle t returns data in cycle t+MEM_LAT.
  - lane_rdata/lane_rvalid are visible in cycle t+MEM_LAT+1.
  - done occurs in cycle K+MEM_LAT+1, the same cycle the final lane_rvalid rises.
- lane_en==0: done in cycle 1, no memory traffic.
- Each mem_ready=0 cycle during ISSUE delays completion by exactly one cycle.

## Structure
- Shared package sp_pkg:
  - state encoding constants (IDLE/ISSUE/DRAIN/DONE)
  - MEM_LAT range limits
  - lane-packing index helpers, also used by the SP core array
- One sub-module, sp_lowest_pending: a combinational N_LANES priority encoder returning the lowest pending index and an any-pending flag.
- Address compare and coalesce mask are inline in the sequencer.

## Test plan
- Load with N_LANES=8, lane_en=8'hFF, addr_i=i*2, COALESCE=1, MEM_LAT=1, mem_ready=1 -> 8 requests in cycles 1..8; lane_rdata_i = memory[i*2]; done in cycle 10; lane_rvalid=8'hFF.
- Coalesced load with lane_en=8'hFF, all addrs 0x0040 -> exactly 1 request; all lanes get the same data; done in cycle 3. Same stimulus with COALESCE=0 -> 8 requests.
- Store with lane_en=8'b1010_0101, lanes 0 and 7 both addressed 0x0010 -> 4 requests in ascending lane order; memory[0x10] = lane 7 data; done in cycle 5; lane_rvalid stays 0.
- Backpressure: mem_ready low in cycles 2-4 during a 4-lane load -> mem_addr held stable across stall; done 3 cycles later than the unstalled run.
- Edge starts: lane_en=0 -> done in cycle 1, mem_req never high. start pulsed while busy -> ignored, no extra requests.
- Mid-op reset: reset=0 in cycle 3 of an 8-lane load -> all outputs 0 immediately; after release, no lane_rvalid from stale returns; the next start behaves normally.
